// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//   Shared constants for the clock/alarm seven-segment display path, plus a
//   constant-evaluable ceil(log2) helper used to size indices and counters.
// ---------------------------------------------------------------------------
package clock_pkg;

  localparam int CH_DIGITS  = 4;       // digits on the display
  localparam int DIGIT_W    = 4;       // BCD digit width
  localparam int SCAN_DIV   = 100000;  // clk cycles per scan step
  localparam int SCAN_GUARD = 2;       // anode-off cycles after a digit change

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//   Free-running prescaler 0..DIV-1 that emits a one-cycle pulse in the cycle
//   after the count reaches DIV-1. Shared by the display scanner and the
//   seconds generator.
//
// Ports
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   en     in  1 = count; 0 = hold count and suppress tick
//   tick   out one-cycle pulse on each wrap
// ---------------------------------------------------------------------------
module tick_gen
  import clock_pkg::*;
#(
  parameter int DIV = SCAN_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would chain r_cnt into r_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= en && (r_cnt == LAST);
      if (en) begin
        r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      end
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/scan_mux_n.sv
// ---------------------------------------------------------------------------
// scan_mux_n
//   N-channel, W-bit time-multiplexer for the seven-segment display. Scans
//   channels automatically at the prescaler rate or holds a manually selected
//   channel; drives registered digit data and active-low one-hot anodes, with
//   GUARD cycles of all-off anodes after every channel change to suppress
//   ghosting.
//
// Ports
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   en          in  scan enable; 0 freezes prescaler, index and guard
//   mode        in  0 = auto scan, 1 = manual select
//   sel_man     in  manual channel index (ignored if >= CH)
//   data_in     in  packed channels, channel k = data_in[k*W +: W]
//   blank_mask  in  1 = keep anode k off
//   dout        out registered data of the current channel
//   sel_out     out registered current channel index
//   an_n        out registered active-low one-hot anode enables
//   tick        out prescaler wrap pulse
// ---------------------------------------------------------------------------
module scan_mux_n
  import clock_pkg::*;
#(
  parameter  int CH    = CH_DIGITS,
  parameter  int W     = DIGIT_W,
  parameter  int DIV   = SCAN_DIV,
  parameter  int GUARD = SCAN_GUARD,
  localparam int SW    = clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   sel_man,
  input  logic [CH*W-1:0] data_in,
  input  logic [CH-1:0]   blank_mask,
  output logic [W-1:0]    dout,
  output logic [SW-1:0]   sel_out,
  output logic [CH-1:0]   an_n,
  output logic            tick
);

  localparam int            GW         = (GUARD > 0) ? clog2(GUARD + 1) : 1;
  localparam logic [SW-1:0] LAST_IDX   = SW'(CH - 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD);

  logic          w_tick;
  logic [SW-1:0] r_idx;
  logic [SW-1:0] w_idx_nxt;
  logic [GW-1:0] r_guard;
  logic [GW-1:0] w_guard_nxt;
  logic [W-1:0]  r_dout;
  logic [W-1:0]  w_dout;
  logic [SW-1:0] r_sel;
  logic [CH-1:0] r_an;
  logic [CH-1:0] w_an;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (w_tick)
  );

  // Next channel index. Manual selection overrides a coincident tick; an
  // out-of-range manual index leaves the current channel in place.
  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_idx_nxt = r_idx;
    if (en) begin
      if (mode) begin
        if (int'(sel_man) < CH) w_idx_nxt = sel_man;
      end else if (w_tick) begin
        w_idx_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end
    end
  end

  // Guard counter: reloads on any channel change, otherwise counts down to 0.
  always_comb begin
    w_guard_nxt = r_guard;
    if (en) begin
      if (w_idx_nxt != r_idx) begin
        w_guard_nxt = GUARD_LOAD;
      end else if (r_guard != '0) begin
        w_guard_nxt = r_guard - 1'b1;
      end
    end
  end

  // Data mux and anode decode from the current (registered) index, so the
  // output register lands one cycle after an index or data change.
  always_comb begin
    w_dout = '0;
    w_an   = '1;
    for (int k = 0; k < CH; k++) begin
      if (r_idx == SW'(k)) begin
        w_dout = data_in[k*W +: W];
        if ((r_guard == '0) && !blank_mask[k]) w_an[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_guard <= '0;
      r_dout  <= '0;
      r_sel   <= '0;
      r_an    <= '1;
    end else begin
      r_idx   <= w_idx_nxt;
      r_guard <= w_guard_nxt;
      r_dout  <= w_dout;
      r_sel   <= r_idx;
      r_an    <= w_an;
    end
  end

  assign dout    = r_dout;
  assign sel_out = r_sel;
  assign an_n    = r_an;
  assign tick    = w_tick;

endmodule
